// File: rtl/ft_alu_retry_ctrl.sv
// ft_alu_retry_ctrl
// Sequencing controller for the dual-rail fault-tolerant 3-bit ALU.
//
// The controller accepts an operation on a valid/ready request port and
// drives the ALU operand, parity and one-hot control inputs from registers.
// After SETTLE_CYC cycles it samples both result rails. If the result is
// trustworthy it is returned on the response port. Otherwise the controller
// flushes the control inputs to 000 and re-issues the operation from a
// shadow copy, up to MAX_RETRY times. Once that budget is spent it reports
// a fatal response.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_a/b/par/op          operands, parity bit, one-hot control {C2,C1,C0}
//   alu_a/b/par/c           registered drive to the ALU inputs
//   alu_x/xc/xe, alu_y/yc/ye  ALU result rails and their error pairs
//   resp_valid/resp_ready   response handshake
//   resp_sum/carry/src      delivered result; src 0 = X rail, 1 = Y rail
//   resp_fatal              retry budget exhausted, result untrusted
//   resp_disagree           both rails were clean but differed on some attempt
//   resp_retries            number of re-issues used
//
// Optional feature (macro FT_ALU_STATS_EN): adds the saturating 16-bit
// counters stat_ok, stat_corrected and stat_fatal.

module ft_alu_retry_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned RCNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_a,
  input  logic [2:0]        req_b,
  input  logic              req_par,
  input  logic [2:0]        req_op,
  output logic [2:0]        alu_a,
  output logic [2:0]        alu_b,
  output logic              alu_par,
  output logic [2:0]        alu_c,
  input  logic [2:0]        alu_x,
  input  logic              alu_xc,
  input  logic [1:0]        alu_xe,
  input  logic [2:0]        alu_y,
  input  logic              alu_yc,
  input  logic [1:0]        alu_ye,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [2:0]        resp_sum,
  output logic              resp_carry,
  output logic              resp_src,
  output logic              resp_fatal,
  output logic              resp_disagree,
  output logic [RCNT_W-1:0] resp_retries
`ifdef FT_ALU_STATS_EN
  ,
  output logic [15:0]       stat_ok,
  output logic [15:0]       stat_corrected,
  output logic [15:0]       stat_fatal
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              dis_q, dis_d;
  logic [2:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_c_q, alu_c_d;
  logic              alu_par_q, alu_par_d;
  logic [2:0]        sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d;
  logic              sh_par_q, sh_par_d;
  logic              rv_q, rv_d;
  logic [2:0]        rsum_q, rsum_d;
  logic              rcarry_q, rcarry_d, rsrc_q, rsrc_d;
  logic              rfatal_q, rfatal_d, rdis_q, rdis_d;
  logic [RCNT_W-1:0] rret_q, rret_d;

  logic x_clean, y_clean, agree, sample, last_try;
  logic take_x, take_y, fail, dis_now;

  // Error pair 10 is the only clean code; 00 and 11 both flag a fault.
  assign x_clean  = (alu_xe == 2'b10);
  assign y_clean  = (alu_ye == 2'b10);
  assign agree    = ({alu_xc, alu_x} == {alu_yc, alu_y});
  assign sample   = (state_q == S_SETTLE) && (cnt_q == 4'(SETTLE_CYC));
  assign last_try = (rcnt_q == RCNT_W'(MAX_RETRY));
  assign take_x   = x_clean && (!y_clean || agree);
  assign take_y   = y_clean && !x_clean;
  assign fail     = !(take_x || take_y);
  assign dis_now  = x_clean && y_clean && !agree;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    dis_d     = dis_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_par_d = alu_par_q;
    alu_c_d   = alu_c_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    sh_par_d  = sh_par_q;
    sh_c_d    = sh_c_q;
    rv_d      = rv_q;
    rsum_d    = rsum_q;
    rcarry_d  = rcarry_q;
    rsrc_d    = rsrc_q;
    rfatal_d  = rfatal_q;
    rdis_d    = rdis_q;
    rret_d    = rret_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_par_d = req_par;
          alu_c_d   = req_op;
          sh_a_d    = req_a;
          sh_b_d    = req_b;
          sh_par_d  = req_par;
          sh_c_d    = req_op;
          rcnt_d    = '0;
          dis_d     = 1'b0;
          cnt_d     = 4'd1;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!sample) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          dis_d   = dis_q || dis_now;
          alu_c_d = '0;
          if (!fail || last_try) begin
            // A fatal delivery falls back to the X rail (take_y is 0 then).
            rv_d     = 1'b1;
            rsum_d   = take_y ? alu_y  : alu_x;
            rcarry_d = take_y ? alu_yc : alu_xc;
            rsrc_d   = take_y;
            rfatal_d = fail;
            rdis_d   = dis_q || dis_now;
            rret_d   = rcnt_q;
            state_d  = S_RESP;
          end else begin
            rcnt_d  = rcnt_q + 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Reloading from the shadow copy forces a fresh input transition.
        alu_a_d   = sh_a_q;
        alu_b_d   = sh_b_q;
        alu_par_d = sh_par_q;
        alu_c_d   = sh_c_q;
        cnt_d     = 4'd1;
        state_d   = S_SETTLE;
      end
      default: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      dis_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_par_q <= 1'b0;
      alu_c_q   <= '0;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      sh_par_q  <= 1'b0;
      sh_c_q    <= '0;
      rv_q      <= 1'b0;
      rsum_q    <= '0;
      rcarry_q  <= 1'b0;
      rsrc_q    <= 1'b0;
      rfatal_q  <= 1'b0;
      rdis_q    <= 1'b0;
      rret_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      dis_q     <= dis_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_par_q <= alu_par_d;
      alu_c_q   <= alu_c_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      sh_par_q  <= sh_par_d;
      sh_c_q    <= sh_c_d;
      rv_q      <= rv_d;
      rsum_q    <= rsum_d;
      rcarry_q  <= rcarry_d;
      rsrc_q    <= rsrc_d;
      rfatal_q  <= rfatal_d;
      rdis_q    <= rdis_d;
      rret_q    <= rret_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_par       = alu_par_q;
  assign alu_c         = alu_c_q;
  assign resp_valid    = rv_q;
  assign resp_sum      = rsum_q;
  assign resp_carry    = rcarry_q;
  assign resp_src      = rsrc_q;
  assign resp_fatal    = rfatal_q;
  assign resp_disagree = rdis_q;
  assign resp_retries  = rret_q;

`ifdef FT_ALU_STATS_EN
  logic [15:0] st_ok_q, st_ok_d, st_cor_q, st_cor_d, st_fat_q, st_fat_d;
  logic        inc_ok, inc_cor, inc_fat;

  assign inc_ok  = sample && x_clean && y_clean && agree && (rcnt_q == '0);
  assign inc_cor = sample && !fail && (take_y || !y_clean || (rcnt_q != '0));
  assign inc_fat = sample && fail && last_try;

  always_comb begin
    st_ok_d  = st_ok_q;
    st_cor_d = st_cor_q;
    st_fat_d = st_fat_q;
    if (inc_ok  && (st_ok_q  != '1)) st_ok_d  = st_ok_q  + 16'd1;
    if (inc_cor && (st_cor_q != '1)) st_cor_d = st_cor_q + 16'd1;
    if (inc_fat && (st_fat_q != '1)) st_fat_d = st_fat_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_ok_q  <= '0;
      st_cor_q <= '0;
      st_fat_q <= '0;
    end else begin
      st_ok_q  <= st_ok_d;
      st_cor_q <= st_cor_d;
      st_fat_q <= st_fat_d;
    end
  end

  assign stat_ok        = st_ok_q;
  assign stat_corrected = st_cor_q;
  assign stat_fatal     = st_fat_q;
`endif

endmodule

// File: tb/tb_ft_alu_retry_ctrl.sv
// Testbench for ft_alu_retry_ctrl (SETTLE_CYC = 2, MAX_RETRY = 3).
// ALU rails are driven directly by the bench: one set of rail values for
// attempt 0 and a second set that takes over during the first FLUSH cycle.
module tb_ft_alu_retry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [2:0] req_a, req_b, req_op;
  logic       req_par;
  logic [2:0] alu_a, alu_b, alu_c;
  logic       alu_par;
  logic [2:0] alu_x, alu_y;
  logic       alu_xc, alu_yc;
  logic [1:0] alu_xe, alu_ye;
  logic       resp_valid, resp_ready;
  logic [2:0] resp_sum;
  logic       resp_carry, resp_src, resp_fatal, resp_disagree;
  logic [2:0] resp_retries;
`ifdef FT_ALU_STATS_EN
  logic [15:0] stat_ok, stat_corrected, stat_fatal;
`endif

  ft_alu_retry_ctrl #(.SETTLE_CYC(2), .MAX_RETRY(3), .RCNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_par(req_par), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_par(alu_par), .alu_c(alu_c),
    .alu_x(alu_x), .alu_xc(alu_xc), .alu_xe(alu_xe),
    .alu_y(alu_y), .alu_yc(alu_yc), .alu_ye(alu_ye),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_carry(resp_carry), .resp_src(resp_src),
    .resp_fatal(resp_fatal), .resp_disagree(resp_disagree),
    .resp_retries(resp_retries)
`ifdef FT_ALU_STATS_EN
    , .stat_ok(stat_ok), .stat_corrected(stat_corrected), .stat_fatal(stat_fatal)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] a; logic [2:0] b; logic par; logic [2:0] op;
    logic [2:0] x0; logic xc0; logic [1:0] xe0; logic [2:0] y0; logic yc0; logic [1:0] ye0;
    logic [2:0] x1; logic xc1; logic [1:0] xe1; logic [2:0] y1; logic yc1; logic [1:0] ye1;
    logic [2:0] e_sum; logic e_carry; logic e_src; logic e_fatal; logic e_dis;
    int unsigned e_ret; int unsigned e_lat; int unsigned e_drv;
  } vec_t;

  localparam int unsigned NV = 9;
  vec_t vecs [NV];

  task automatic set_rails(input logic [2:0] x, input logic xc, input logic [1:0] xe,
                           input logic [2:0] y, input logic yc, input logic [1:0] ye);
    alu_x = x; alu_xc = xc; alu_xe = xe;
    alu_y = y; alu_yc = yc; alu_ye = ye;
  endtask

  task automatic run_vec(input int unsigned i, input vec_t v);
    int unsigned t0, k, drv;
    logic [2:0] prev_c;
    string tag;
    tag = $sformatf("v%0d", i);
    @(negedge clk);
    set_rails(v.x0, v.xc0, v.xe0, v.y0, v.yc0, v.ye0);
    req_a = v.a; req_b = v.b; req_par = v.par; req_op = v.op; req_valid = 1'b1;
    check({tag, ".req_ready_idle"}, req_ready, 1);
    prev_c = alu_c;
    @(negedge clk);
    t0 = cyc;
    req_valid = 1'b0;
    check({tag, ".alu_a"}, alu_a, v.a);
    check({tag, ".alu_b"}, alu_b, v.b);
    check({tag, ".alu_par"}, alu_par, v.par);
    check({tag, ".req_ready_busy"}, req_ready, 0);
    k = 0; drv = 0;
    while (!resp_valid && k < 40) begin
      if (alu_c != 3'b000 && prev_c == 3'b000) drv++;
      prev_c = alu_c;
      if (k == 2 && v.e_lat > 2) begin
        check({tag, ".flush_c"}, alu_c, 0);
        set_rails(v.x1, v.xc1, v.xe1, v.y1, v.yc1, v.ye1);
      end
      if (k == 3 && v.e_lat > 3) check({tag, ".reload_c"}, alu_c, v.op);
      @(negedge clk);
      k = cyc - t0;
    end
    check({tag, ".latency"}, k, v.e_lat);
    check({tag, ".drives"}, drv, v.e_drv);
    check({tag, ".sum"}, resp_sum, v.e_sum);
    check({tag, ".carry"}, resp_carry, v.e_carry);
    check({tag, ".src"}, resp_src, v.e_src);
    check({tag, ".fatal"}, resp_fatal, v.e_fatal);
    check({tag, ".disagree"}, resp_disagree, v.e_dis);
    check({tag, ".retries"}, resp_retries, v.e_ret);
    check({tag, ".c_idle"}, alu_c, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, ".valid_drop"}, resp_valid, 0);
    check({tag, ".ready_back"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    //            a     b   par  op      x0  xc0 xe0    y0  yc0 ye0    x1  xc1 xe1    y1  yc1 ye1    sum carry src fat dis ret lat drv
    vecs[0] = '{3'd3, 3'd2, 1'b0, 3'b001, 3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 1};
    vecs[1] = '{3'd3, 3'd2, 1'b0, 3'b001, 3'd7, 1'b1, 2'b11, 3'd5, 1'b0, 2'b10, 3'd7, 1'b1, 2'b11, 3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 1};
    vecs[2] = '{3'd6, 3'd7, 1'b1, 3'b010, 3'd6, 1'b1, 2'b10, 3'd1, 1'b0, 2'b00, 3'd6, 1'b1, 2'b10, 3'd1, 1'b0, 2'b00, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1};
    vecs[3] = '{3'd3, 3'd2, 1'b0, 3'b001, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00, 3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 5, 2};
    vecs[4] = '{3'd3, 3'd2, 1'b0, 3'b001, 3'd5, 1'b0, 2'b10, 3'd4, 1'b0, 2'b10, 3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 2'b10, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 5, 2};
    vecs[5] = '{3'd1, 3'd1, 1'b1, 3'b100, 3'd2, 1'b0, 2'b00, 3'd3, 1'b0, 2'b00, 3'd2, 1'b0, 2'b00, 3'd3, 1'b0, 2'b00, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3, 11, 4};
    vecs[6] = '{3'd4, 3'd4, 1'b0, 3'b100, 3'd5, 1'b0, 2'b10, 3'd5, 1'b1, 2'b10, 3'd5, 1'b0, 2'b10, 3'd5, 1'b1, 2'b10, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 3, 11, 4};
    vecs[7] = '{3'd2, 3'd5, 1'b1, 3'b010, 3'd3, 1'b1, 2'b01, 3'd6, 1'b0, 2'b11, 3'd3, 1'b1, 2'b01, 3'd6, 1'b0, 2'b11, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3, 11, 4};
    vecs[8] = '{3'd0, 3'd0, 1'b0, 3'b001, 3'd1, 1'b0, 2'b00, 3'd1, 1'b0, 2'b00, 3'd7, 1'b1, 2'b00, 3'd2, 1'b1, 2'b10, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1, 5, 2};

    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_a = '0; req_b = '0; req_par = 1'b0; req_op = '0;
    set_rails(3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    check("rst.req_ready", req_ready, 1);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.alu_c", alu_c, 0);
    check("rst.alu_a", alu_a, 0);
    check("rst.retries", resp_retries, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Response stall with requests offered (must be ignored), then reset mid-RESP.
    @(negedge clk);
    set_rails(3'd7, 1'b1, 2'b10, 3'd7, 1'b1, 2'b10);
    req_a = 3'd1; req_b = 3'd6; req_par = 1'b1; req_op = 3'b100; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("stall.latency", k, 2);
    req_a = 3'd0; req_op = 3'b001; req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall.valid", resp_valid, 1);
      check("stall.sum", resp_sum, 7);
      check("stall.carry", resp_carry, 1);
      check("stall.alu_a", alu_a, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst.resp_valid", resp_valid, 0);
    check("arst.req_ready", req_ready, 1);
    check("arst.alu_c", alu_c, 0);
    check("arst.resp_sum", resp_sum, 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.req_ready", req_ready, 1);
    check("post_rst.resp_valid", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
